// File: rtl/mm_read_arbiter_pkg.sv
// Shared types and constants for the round-robin Avalon-MM read arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } arb_state_t;

    localparam int ARB_MAX_REQ         = 8;
    localparam int ARB_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mm_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        logic [PTR_W:0] idx;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (idx >= NUM_REQ_W) begin
                idx = idx - NUM_REQ_W;
            end
            if (!any && req[idx[PTR_W-1:0]]) begin
                any       = 1'b1;
                grant_idx = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mm_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM read port among NUM_REQ masters, one read in flight.
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
module mm_read_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = ARB_DEFAULT_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_read,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_address,
    output logic [NUM_REQ-1:0]             req_waitrequest,
    output logic [NUM_REQ-1:0]             req_readdatavalid,
    output logic [DATA_W-1:0]              req_readdata,
    output logic [ADDR_W-1:0]              mm_address,
    output logic                           mm_read,
    input  logic [DATA_W-1:0]              mm_readdata,
    input  logic                           mm_readdatavalid,
    input  logic                           mm_waitrequest,
    output logic [2:0]                     grant_id,
    output logic                           busy,
    output logic                           err_spurious,
    output logic                           err_timeout
);

    localparam int             PTR_W     = $clog2(NUM_REQ);
    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

    arb_state_t       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;
    logic [PTR_W:0]   ptr_inc;
    logic [PTR_W-1:0] next_ptr;
    logic             accept;
    logic             resp_hit;
    logic             timeout_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req       (req_read),
        .ptr       (rr_ptr),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Explicit wrap keeps non-power-of-2 requester counts legal.
    assign ptr_inc  = {1'b0, grant} + (PTR_W + 1)'(1);
    assign next_ptr = (ptr_inc >= NUM_REQ_W) ? '0 : ptr_inc[PTR_W-1:0];

    assign accept   = (state == ISSUE) && mm_read && !mm_waitrequest && !rst;
    assign resp_hit = (state == WAIT_RESP) && mm_readdatavalid && !rst;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] wd_cnt;

    // Held at zero through ISSUE so the count starts fresh on entry to WAIT_RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == ISSUE) begin
            wd_cnt <= '0;
        end else if (state == WAIT_RESP) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    // A real response on the expiry cycle wins over the watchdog.
    assign timeout_hit = (state == WAIT_RESP) && !mm_readdatavalid && !rst &&
                         (wd_cnt == CNT_W'(TIMEOUT_CYC));
`else
    // TIMEOUT_CYC is always positive, so the watchdog never fires in this build.
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            mm_read      <= 1'b0;
            mm_address   <= '0;
            err_spurious <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_spurious <= mm_readdatavalid && (state != WAIT_RESP);
            err_timeout  <= timeout_hit;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant      <= pick_idx;
                        mm_read    <= 1'b1;
                        mm_address <= req_address[pick_idx];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!mm_waitrequest) begin
                        mm_read <= 1'b0;
                        state   <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (resp_hit || timeout_hit) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_waitrequest   = '1;
        req_readdatavalid = '0;
        req_readdata      = '0;
        if (accept) begin
            req_waitrequest[grant] = 1'b0;
        end
        if (resp_hit) begin
            req_readdatavalid[grant] = 1'b1;
            req_readdata             = mm_readdata;
        end else if (timeout_hit) begin
            req_readdatavalid[grant] = 1'b1;
        end
    end

    assign busy     = (state != IDLE);
    assign grant_id = 3'(grant);

endmodule

// File: tb/tb_mm_read_arbiter.sv
// Directed bench for mm_read_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_mm_read_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_read;
    logic [1:0][31:0]  req_address;
    logic [1:0]        req_waitrequest;
    logic [1:0]        req_readdatavalid;
    logic [63:0]       req_readdata;
    logic [31:0]       mm_address;
    logic              mm_read;
    logic [63:0]       mm_readdata;
    logic              mm_readdatavalid;
    logic              mm_waitrequest;
    logic [2:0]        grant_id;
    logic              busy;
    logic              err_spurious;
    logic              err_timeout;

    mm_read_arbiter #(
        .NUM_REQ     (2),
        .ADDR_W      (32),
        .DATA_W      (64),
        .TIMEOUT_CYC (10)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_read          (req_read),
        .req_address       (req_address),
        .req_waitrequest   (req_waitrequest),
        .req_readdatavalid (req_readdatavalid),
        .req_readdata      (req_readdata),
        .mm_address        (mm_address),
        .mm_read           (mm_read),
        .mm_readdata       (mm_readdata),
        .mm_readdatavalid  (mm_readdatavalid),
        .mm_waitrequest    (mm_waitrequest),
        .grant_id          (grant_id),
        .busy              (busy),
        .err_spurious      (err_spurious),
        .err_timeout       (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rd;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        wt;
        logic        rdv;
        logic [63:0] din;
        logic        e_rd;
        logic [31:0] e_addr;
        logic [1:0]  e_wait;
        logic [1:0]  e_rdv;
        logic [63:0] e_data;
        logic [2:0]  e_grant;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [63:0] D0 = 64'h1111_0000_0000_0001;
    localparam logic [63:0] D1 = 64'h2222_0000_0000_0002;
    localparam logic [63:0] D2 = 64'h3333_0000_0000_0003;
    localparam logic [63:0] D3 = 64'h4444_0000_0000_0004;
    localparam logic [63:0] DT = 64'h0102_0304_0506_0708;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [1:0] rd, input logic [31:0] a0, input logic [31:0] a1,
                       input logic wt, input logic rdv, input logic [63:0] din,
                       input logic e_rd, input logic [31:0] e_addr, input logic [1:0] e_wait,
                       input logic [1:0] e_rdv, input logic [63:0] e_data,
                       input logic [2:0] e_grant, input logic e_busy);
        vec_t v;
        v.rd = rd; v.a0 = a0; v.a1 = a1; v.wt = wt; v.rdv = rdv; v.din = din;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_wait = e_wait; v.e_rdv = e_rdv;
        v.e_data = e_data; v.e_grant = e_grant; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_read = '0; req_address = '0;
        mm_readdata = '0; mm_readdatavalid = 1'b0; mm_waitrequest = 1'b0;

        // Round robin: both masters request every cycle, zero wait states, immediate response.
        add(2'b11, 32'h10, 32'h20, 0, 0, 0,  0, 32'h00, 2'b11, 2'b00, 0,  0, 0);
        add(2'b11, 32'h10, 32'h20, 0, 0, 0,  1, 32'h10, 2'b10, 2'b00, 0,  0, 1);
        add(2'b11, 32'h10, 32'h20, 0, 1, D0, 0, 32'h10, 2'b11, 2'b01, D0, 0, 1);
        add(2'b11, 32'h10, 32'h20, 0, 0, 0,  0, 32'h10, 2'b11, 2'b00, 0,  0, 0);
        add(2'b11, 32'h10, 32'h20, 0, 0, 0,  1, 32'h20, 2'b01, 2'b00, 0,  1, 1);
        add(2'b11, 32'h10, 32'h20, 0, 1, D1, 0, 32'h20, 2'b11, 2'b10, D1, 1, 1);
        add(2'b11, 32'h10, 32'h20, 0, 0, 0,  0, 32'h20, 2'b11, 2'b00, 0,  1, 0);
        add(2'b11, 32'h10, 32'h20, 0, 0, 0,  1, 32'h10, 2'b10, 2'b00, 0,  0, 1);
        add(2'b11, 32'h10, 32'h20, 0, 1, D2, 0, 32'h10, 2'b11, 2'b01, D2, 0, 1);
        add(2'b11, 32'h10, 32'h20, 0, 0, 0,  0, 32'h10, 2'b11, 2'b00, 0,  0, 0);
        add(2'b11, 32'h10, 32'h20, 0, 0, 0,  1, 32'h20, 2'b01, 2'b00, 0,  1, 1);
        add(2'b11, 32'h10, 32'h20, 0, 1, D3, 0, 32'h20, 2'b11, 2'b10, D3, 1, 1);
        // Single master 0 at address 3, response two cycles after acceptance.
        add(2'b01, 32'h03, 32'h20, 0, 0, 0,  0, 32'h20, 2'b11, 2'b00, 0,  1, 0);
        add(2'b01, 32'h03, 32'h20, 0, 0, 0,  1, 32'h03, 2'b10, 2'b00, 0,  0, 1);
        add(2'b00, 32'h03, 32'h20, 0, 0, 0,  0, 32'h03, 2'b11, 2'b00, 0,  0, 1);
        add(2'b00, 32'h03, 32'h20, 0, 1, DT, 0, 32'h03, 2'b11, 2'b01, DT, 0, 1);
        add(2'b00, 32'h03, 32'h20, 0, 0, 0,  0, 32'h03, 2'b11, 2'b00, 0,  0, 0);

        tick(); tick();
        check("reset mm_read", 64'(mm_read), 0);
        check("reset mm_address", 64'(mm_address), 0);
        check("reset req_waitrequest", 64'(req_waitrequest), 64'h3);
        check("reset req_readdatavalid", 64'(req_readdatavalid), 0);
        check("reset req_readdata", req_readdata, 0);
        check("reset grant_id", 64'(grant_id), 0);
        check("reset busy", 64'(busy), 0);
        check("reset err_spurious", 64'(err_spurious), 0);
        check("reset err_timeout", 64'(err_timeout), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            req_read = vecs[i].rd;
            req_address[0] = vecs[i].a0;
            req_address[1] = vecs[i].a1;
            mm_waitrequest = vecs[i].wt;
            mm_readdatavalid = vecs[i].rdv;
            mm_readdata = vecs[i].din;
            #1;
            check($sformatf("vec%0d mm_read", i), 64'(mm_read), 64'(vecs[i].e_rd));
            check($sformatf("vec%0d mm_address", i), 64'(mm_address), 64'(vecs[i].e_addr));
            check($sformatf("vec%0d req_waitrequest", i), 64'(req_waitrequest), 64'(vecs[i].e_wait));
            check($sformatf("vec%0d req_readdatavalid", i), 64'(req_readdatavalid), 64'(vecs[i].e_rdv));
            check($sformatf("vec%0d req_readdata", i), req_readdata, vecs[i].e_data);
            check($sformatf("vec%0d grant_id", i), 64'(grant_id), 64'(vecs[i].e_grant));
            check($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
            check($sformatf("vec%0d err_spurious", i), 64'(err_spurious), 0);
            tick();
        end
        mm_readdatavalid = 1'b0; mm_readdata = '0;

        // Slave stalls five cycles in ISSUE (pointer is now 1, master 1 only).
        req_read = 2'b10; req_address[1] = 32'h55; mm_waitrequest = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) req_address[1] = 32'h66;
            #1;
            check($sformatf("stall%0d mm_read", i), 64'(mm_read), 1);
            check($sformatf("stall%0d mm_address", i), 64'(mm_address), 32'h55);
            check($sformatf("stall%0d req_waitrequest", i), 64'(req_waitrequest), 64'h3);
            check($sformatf("stall%0d grant_id", i), 64'(grant_id), 1);
            tick();
        end
        mm_waitrequest = 1'b0;
        #1;
        check("stall accept req_waitrequest", 64'(req_waitrequest), 64'h1);
        tick();
        req_read = 2'b00; mm_readdatavalid = 1'b1; mm_readdata = 64'hCAFE;
        #1;
        check("stall resp req_readdatavalid", 64'(req_readdatavalid), 64'h2);
        check("stall resp req_readdata", req_readdata, 64'hCAFE);
        tick();
        mm_readdatavalid = 1'b0;

        // Master 0 drops read during ISSUE; the command and response still complete.
        req_read = 2'b01; req_address[0] = 32'h77; mm_waitrequest = 1'b1;
        tick();
        req_read = 2'b00;
        #1;
        check("drop mm_read", 64'(mm_read), 1);
        tick();
        mm_waitrequest = 1'b0;
        #1;
        check("drop accept req_waitrequest", 64'(req_waitrequest), 64'h2);
        tick();
        mm_readdatavalid = 1'b1; mm_readdata = 64'hBEEF;
        #1;
        check("drop resp req_readdatavalid", 64'(req_readdatavalid), 64'h1);
        check("drop resp req_readdata", req_readdata, 64'hBEEF);
        tick();

        // Spurious response while IDLE.
        mm_readdata = 64'hDEAD;
        #1;
        check("spur req_readdatavalid", 64'(req_readdatavalid), 0);
        check("spur req_readdata", req_readdata, 0);
        tick();
        mm_readdatavalid = 1'b0;
        #1;
        check("spur err_spurious pulse", 64'(err_spurious), 1);
        check("spur busy", 64'(busy), 0);
        tick();
        check("spur err_spurious clear", 64'(err_spurious), 0);
        check("spur still idle", 64'(busy), 0);

        // Reset during WAIT_RESP; the late response is dropped and flagged.
        req_read = 2'b01; req_address[0] = 32'h44;
        tick();
        tick();
        req_read = 2'b00;
        #1;
        check("rstmid busy before", 64'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstmid busy", 64'(busy), 0);
        check("rstmid mm_read", 64'(mm_read), 0);
        check("rstmid mm_address", 64'(mm_address), 0);
        check("rstmid grant_id", 64'(grant_id), 0);
        tick();
        mm_readdatavalid = 1'b1; mm_readdata = 64'h99;
        #1;
        check("rstmid late req_readdatavalid", 64'(req_readdatavalid), 0);
        tick();
        mm_readdatavalid = 1'b0;
        #1;
        check("rstmid err_spurious", 64'(err_spurious), 1);

        // Pointer restarts at 0 after reset; then the response path (or watchdog) ends it.
        req_read = 2'b11; req_address[1] = 32'h20;
        tick();
        check("post-rst grant_id", 64'(grant_id), 0);
        check("post-rst mm_address", 64'(mm_address), 32'h44);
        tick();
        req_read = 2'b00;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("wd wait%0d req_readdatavalid", i), 64'(req_readdatavalid), 0);
            tick();
        end
        #1;
        check("wd expiry req_readdatavalid", 64'(req_readdatavalid), 64'h1);
        check("wd expiry req_readdata", req_readdata, 0);
        tick();
        check("wd err_timeout", 64'(err_timeout), 1);
        check("wd busy", 64'(busy), 0);
`else
        mm_readdatavalid = 1'b1; mm_readdata = 64'h5A;
        #1;
        check("final resp req_readdatavalid", 64'(req_readdatavalid), 64'h1);
        check("final resp req_readdata", req_readdata, 64'h5A);
        tick();
        mm_readdatavalid = 1'b0;
        check("final err_timeout", 64'(err_timeout), 0);
        check("final busy", 64'(busy), 0);
`endif
        req_read = 2'b11;
        tick();
        check("next grant_id", 64'(grant_id), 1);
        check("next mm_address", 64'(mm_address), 32'h20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mm_read_arbiter.md
# mm_read_arbiter

Round-robin arbiter that shares the single 64-bit Avalon-MM read port of `mem_wrapper` among `NUM_REQ` read masters, such as the row fetcher and a second fetch/readback engine. It allows exactly one outstanding transaction at a time. It holds the grant from command issue until `readdatavalid` returns, then routes the response to the granted master only. It sits between the masters and `mem_wrapper`, and each master keeps its native Avalon-MM master signalling unchanged.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, legal range 2–8.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 64: read data width.
- `TIMEOUT_CYC`, default 255: response watchdog limit in cycles. Used only with `ARB_TIMEOUT_EN`.

Ports (all outputs are synchronous to `clk`):
- `clk`  in  1  Single clock.
- `rst`  in  1  Synchronous, active-high reset.
- `req_read`  in  NUM_REQ  Per-master read request.
- `req_address`  in  NUM_REQ x ADDR_W  Per-master address.
- `req_waitrequest`  out  NUM_REQ  Per-master stall.
- `req_readdatavalid`  out  NUM_REQ  Per-master response strobe.
- `req_readdata`  out  DATA_W  Read data, broadcast to all masters. Qualified by `req_readdatavalid`.
- `mm_address`  out  ADDR_W  Slave-side address.
- `mm_read`  out  1  Slave-side read strobe.
- `mm_readdata`  in  DATA_W  Slave-side read data.
- `mm_readdatavalid`  in  1  Slave-side response strobe.
- `mm_waitrequest`  in  1  Slave-side stall.
- `grant_id`  out  3  Index of the current or last granted master.
- `busy`  out  1  High whenever the state is not IDLE.
- `err_spurious`  out  1  One-cycle pulse when `mm_readdatavalid` arrives outside WAIT_RESP.
- `err_timeout`  out  1  One-cycle pulse on watchdog expiry.

## Operation
The arbiter has three states: IDLE, ISSUE and WAIT_RESP.

IDLE:
- `req_read` is sampled only in IDLE.
- If any request bit is set, grant the first set index at or after `rr_ptr`, searching upward with wrap. Register the result into `grant_id` and move to ISSUE.
- If no request bit is set, stay in IDLE.

ISSUE:
- `mm_read` = 1 and `mm_address` = `req_address[grant_id]`. Both are registered and held stable while `mm_waitrequest` = 1.
- On a cycle where `mm_read` = 1 and `mm_waitrequest` = 0, the command is accepted:
  - Drive `req_waitrequest[grant_id]` = 0 for that cycle only (combinational).
  - `mm_read` goes to 0 on the next cycle, and the state moves to WAIT_RESP.

WAIT_RESP:
- `req_read` from any master is ignored. A master may keep `read` high while it waits.
- When `mm_readdatavalid` = 1, that same cycle (combinational) `req_readdatavalid[grant_id]` = 1 and `req_readdata` = `mm_readdata`.
- The next state is IDLE, and `rr_ptr` becomes (`grant_id` + 1) mod `NUM_REQ`.

Outputs and pointer:
- `req_waitrequest[i]` = 1 in every case except the single acceptance cycle of the granted master.
- `req_readdatavalid[i]` = 0 except for the granted master in its response cycle.
- `rr_ptr` width is clog2(`NUM_REQ`). Wrap is explicit, so non-power-of-2 `NUM_REQ` is legal.

Boundary conditions:
- All masters request simultaneously: served in order `rr_ptr`, `rr_ptr`+1, … with no starvation.
- A master that drops `read` in ISSUE violates the Avalon protocol. The arbiter keeps issuing and still delivers the response.
- `mm_readdatavalid` in IDLE or ISSUE: the data is discarded, `err_spurious` pulses, and the state is unchanged.
- `rst` mid-transaction: the state returns to IDLE the next cycle and any in-flight response is discarded. A late `mm_readdatavalid` then raises `err_spurious`.

## Timing
Reset values:
- State = IDLE, `rr_ptr` = 0, `grant_id` = 0.
- `mm_read` = 0, `mm_address` = 0.
- `req_waitrequest` = all 1s, `req_readdatavalid` = 0, `req_readdata` = 0.
- `busy` = 0, `err_spurious` = 0, `err_timeout` = 0.

Latency:
- A request seen in IDLE at cycle N produces `mm_read` = 1 at cycle N+1.
- With zero wait states, acceptance occurs at N+1 and the earliest response at N+2.
- IDLE lasts a minimum of 1 cycle between transactions, so back-to-back throughput is 1 read per 3 cycles plus slave latency.

## Configuration
`ARB_TIMEOUT_EN` defined:
- An 8-bit-or-wider counter clears on entry to WAIT_RESP and increments each cycle.
- When the count reaches `TIMEOUT_CYC` with no response:
  - `req_readdatavalid[grant_id]` pulses with `req_readdata` = 0.
  - `err_timeout` pulses.
  - The state returns to IDLE and the pointer advances.
- A response arriving on the expiry cycle takes precedence over the timeout.

`ARB_TIMEOUT_EN` undefined:
- No counter is built, and WAIT_RESP waits indefinitely.
- `err_timeout` is tied to 0.

## Structure
- Package `arb_pkg`: `arb_state_t` enum {IDLE, ISSUE, WAIT_RESP}, plus constants `ARB_MAX_REQ` = 8 and `ARB_DEFAULT_TIMEOUT` = 255.
- Sub-module `rr_pick`: purely combinational. Takes `req` and `ptr`, returns `grant_idx` and `any`. Instantiated once.

## Test plan
- Single master 0, address 3, `mm_waitrequest` low, response 2 cycles later with data 0x0102030405060708. Required: `mm_address` = 3, then `req_readdatavalid[0]` for 1 cycle with that data, and `req_readdatavalid[1]` = 0 throughout.
- Both masters request continuously for 4 transactions. Required: grants in order 0, 1, 0, 1.
- `mm_waitrequest` held high for 5 cycles in ISSUE. Required: `mm_read` and `mm_address` are stable for all 5 cycles and `req_waitrequest[g]` = 1 until acceptance.
- Spurious `mm_readdatavalid` in IDLE. Required: `err_spurious` pulses once, no `req_readdatavalid`, state stays IDLE.
- `rst` asserted in WAIT_RESP, with the response arriving 2 cycles later. Required: state is IDLE, the response is dropped and `err_spurious` pulses.
- With `ARB_TIMEOUT_EN` and `TIMEOUT_CYC` = 10, no response. Required: `err_timeout` pulses and `req_readdatavalid[g]` = 1 with data 0, then the next master is granted.
